// File: rtl/sdm_read_requester_if.sv
// Handshake bundle between an upstream symbol source, the SDM memory and a
// downstream result consumer, as seen by sdm_read_requester.
//   upstream  : in_valid, in_symbol, in_train  -> ; <- in_ready
//   sdm       : <- sdm_valid, sdm_wnr, sdm_address ; sdm_readValid,
//               sdm_readSuccess, sdm_data ->
//   downstream: <- out_valid, out_symbol, out_hit, out_timeout ; out_ready ->
// The master modport is the requester; the slave modport is its environment.
interface sdm_read_requester_if #(
  parameter int unsigned BIT_WIDTH = 8
);
  logic                 in_valid;
  logic [BIT_WIDTH-1:0] in_symbol;
  logic                 in_train;
  logic                 in_ready;

  logic                 sdm_valid;
  logic                 sdm_wnr;
  logic [BIT_WIDTH-1:0] sdm_address;
  logic                 sdm_readValid;
  logic                 sdm_readSuccess;
  logic [BIT_WIDTH-1:0] sdm_data;

  logic                 out_valid;
  logic [BIT_WIDTH-1:0] out_symbol;
  logic                 out_hit;
  logic                 out_timeout;
  logic                 out_ready;

  modport master (
    input  in_valid, in_symbol, in_train,
    output in_ready,
    output sdm_valid, sdm_wnr, sdm_address,
    input  sdm_readValid, sdm_readSuccess, sdm_data,
    output out_valid, out_symbol, out_hit, out_timeout,
    input  out_ready
  );

  modport slave (
    output in_valid, in_symbol, in_train,
    input  in_ready,
    input  sdm_valid, sdm_wnr, sdm_address,
    output sdm_readValid, sdm_readSuccess, sdm_data,
    input  out_valid, out_symbol, out_hit, out_timeout,
    output out_ready
  );
endinterface

// File: rtl/sdm_read_requester.sv
// Issues train (write) or recall (read) requests to a sparse distributed
// memory for one upstream symbol at a time, waits a bounded time for the
// read response and presents the recalled (or raw) symbol downstream.
// Keeps saturating hit/miss statistics.
// Ports:
//   clk, rstb    clock; asynchronous active-low reset
//   bus          sdm_read_requester_if.master (upstream/SDM/downstream)
//   clear_stats  synchronous clear of both counters (wins over increment)
//   hit_count    successful recalls
//   miss_count   failed or timed-out recalls
module sdm_read_requester #(
  parameter int unsigned BIT_WIDTH  = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstb,
  sdm_read_requester_if.master  bus,
  input  logic                  clear_stats,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [BIT_WIDTH-1:0] sym_q;
  logic                 train_q;
  logic [TW-1:0]        timer;
  logic [BIT_WIDTH-1:0] res_symbol;
  logic                 res_hit;
  logic                 res_timeout;

  logic accept;
  logic resp_load;
  logic resp_hit;
  logic timed_out;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    resp_load = 1'b0;
    resp_hit  = 1'b0;
    timed_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = train_q ? IDLE : WAIT;
      WAIT: begin
        // A response in the final timer cycle still counts as a response.
        if (bus.sdm_readValid) begin
          resp_load = 1'b1;
          resp_hit  = bus.sdm_readSuccess;
          state_n   = RESP;
        end else if (timer == TIMER_LAST) begin
          resp_load = 1'b1;
          timed_out = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state == IDLE);
    bus.sdm_valid   = (state == ISSUE);
    bus.sdm_wnr     = train_q;
    bus.sdm_address = sym_q;
    bus.out_valid   = (state == RESP);
    bus.out_symbol  = res_symbol;
    bus.out_hit     = res_hit;
    bus.out_timeout = res_timeout;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sym_q       <= '0;
      train_q     <= 1'b0;
      timer       <= '0;
      res_symbol  <= '0;
      res_hit     <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        sym_q   <= bus.in_symbol;
        train_q <= bus.in_train;
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);
      if (resp_load) begin
        res_hit     <= resp_hit;
        res_timeout <= timed_out;
        res_symbol  <= resp_hit ? bus.sdm_data : sym_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (clear_stats) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_load) begin
      if (resp_hit) begin
        if (hit_count != '1) hit_count <= hit_count + STAT_WIDTH'(1);
      end else begin
        if (miss_count != '1) miss_count <= miss_count + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdm_read_requester.sv
module tb_sdm_read_requester;

  localparam int unsigned BW = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned NR = 99;   // never respond
  localparam int unsigned NV = 13;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          clear_stats = 1'b0;
  logic [SW-1:0] hit_count;
  logic [SW-1:0] miss_count;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_miss = 0;

  sdm_read_requester_if #(.BIT_WIDTH(BW)) bus ();

  sdm_read_requester #(
    .BIT_WIDTH (BW),
    .TIMEOUT   (TO),
    .STAT_WIDTH(SW)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .bus        (bus),
    .clear_stats(clear_stats),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  sym;
    logic        train;
    int unsigned d;      // cycles after sdm_valid at which readValid is driven
    logic        succ;
    logic [7:0]  data;
    int unsigned hold;   // extra RESP cycles with out_ready=0
    logic        clr;    // clear_stats on the response edge
    logic [7:0]  e_sym;
    logic        e_hit;
    logic        e_to;
    int unsigned e_lat;  // negedges from accept edge to first out_valid
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_hit_count"}, 32'(hit_count), exp_hits);
    chk({tag, "_miss_count"}, 32'(miss_count), exp_miss);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},    32'(bus.in_ready), 32'd1);
    chk({tag, "_sdm_valid"},   32'(bus.sdm_valid), 32'd0);
    chk({tag, "_sdm_wnr"},     32'(bus.sdm_wnr), 32'd0);
    chk({tag, "_sdm_address"}, 32'(bus.sdm_address), 32'd0);
    chk({tag, "_out_valid"},   32'(bus.out_valid), 32'd0);
    chk({tag, "_out_symbol"},  32'(bus.out_symbol), 32'd0);
    chk({tag, "_out_hit"},     32'(bus.out_hit), 32'd0);
    chk({tag, "_out_timeout"}, 32'(bus.out_timeout), 32'd0);
    chk({tag, "_hit_count"},   32'(hit_count), 32'd0);
    chk({tag, "_miss_count"},  32'(miss_count), 32'd0);
  endtask

  task automatic sat_inc(inout int unsigned c);
    if (c < 3) c = c + 1;
  endtask

  task automatic run_vec(input int unsigned i, input vec_t v);
    int unsigned lat;
    string t;
    t = $sformatf("v%0d", i);
    @(negedge clk);
    chk({t, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_symbol = v.sym;
    bus.in_train  = v.train;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    chk({t, "_sdm_valid"},   32'(bus.sdm_valid), 32'd1);
    chk({t, "_sdm_wnr"},     32'(bus.sdm_wnr), 32'(v.train));
    chk({t, "_sdm_address"}, 32'(bus.sdm_address), 32'(v.sym));
    chk({t, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    if (v.train) begin
      @(negedge clk);
      chk({t, "_train_sdm_valid_drop"}, 32'(bus.sdm_valid), 32'd0);
      chk({t, "_train_in_ready"},       32'(bus.in_ready), 32'd1);
      chk({t, "_train_no_out"},         32'(bus.out_valid), 32'd0);
      chk({t, "_train_addr_hold"},      32'(bus.sdm_address), 32'(v.sym));
      chk_counts({t, "_train"});
      return;
    end
    bus.sdm_readSuccess = v.succ;
    bus.sdm_data        = v.data;
    while (!bus.out_valid && lat < 40) begin
      bus.sdm_readValid = (lat == v.d + 1);
      clear_stats       = v.clr && (lat == v.d + 1);
      @(negedge clk);
      lat++;
    end
    bus.sdm_readValid = 1'b0;
    clear_stats       = 1'b0;
    chk({t, "_latency"}, lat, v.e_lat);
    if (!bus.out_valid) return;
    if (v.clr) begin
      exp_hits = 0;
      exp_miss = 0;
    end else if (v.e_hit) sat_inc(exp_hits);
    else                  sat_inc(exp_miss);
    chk({t, "_out_symbol"},  32'(bus.out_symbol), 32'(v.e_sym));
    chk({t, "_out_hit"},     32'(bus.out_hit), 32'(v.e_hit));
    chk({t, "_out_timeout"}, 32'(bus.out_timeout), 32'(v.e_to));
    chk_counts(t);
    for (int unsigned h = 0; h < v.hold; h++) begin
      bus.in_valid      = 1'b1;
      bus.in_symbol     = 8'h5A;
      bus.sdm_readValid = (lat == v.d + 1);
      @(negedge clk);
      lat++;
      chk({t, "_hold_out_valid"},  32'(bus.out_valid), 32'd1);
      chk({t, "_hold_out_symbol"}, 32'(bus.out_symbol), 32'(v.e_sym));
      chk({t, "_hold_out_hit"},    32'(bus.out_hit), 32'(v.e_hit));
      chk({t, "_hold_out_timeout"}, 32'(bus.out_timeout), 32'(v.e_to));
      chk({t, "_hold_in_ready"},   32'(bus.in_ready), 32'd0);
      chk({t, "_hold_sdm_valid"},  32'(bus.sdm_valid), 32'd0);
    end
    if (v.hold != 0) chk_counts({t, "_hold"});
    bus.in_valid      = 1'b0;
    bus.sdm_readValid = 1'b0;
    bus.out_ready     = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({t, "_done_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({t, "_done_in_ready"},  32'(bus.in_ready), 32'd1);
    chk({t, "_done_sdm_valid"}, 32'(bus.sdm_valid), 32'd0);
  endtask

  initial begin
    int unsigned seen;
    //          sym    trn   d    succ  data   hold clr  e_sym  e_hit e_to lat
    vecs[0]  = '{8'hF3, 1'b0, 2,  1'b1, 8'hFF, 0,  1'b0, 8'hFF, 1'b1, 1'b0, 4};
    vecs[1]  = '{8'hAA, 1'b1, 0,  1'b0, 8'h00, 0,  1'b0, 8'h00, 1'b0, 1'b0, 0};
    vecs[2]  = '{8'h5C, 1'b0, NR, 1'b0, 8'h00, 0,  1'b0, 8'h5C, 1'b0, 1'b1, 18};
    vecs[3]  = '{8'h31, 1'b0, 1,  1'b0, 8'h77, 0,  1'b0, 8'h31, 1'b0, 1'b0, 3};
    vecs[4]  = '{8'h42, 1'b0, 0,  1'b1, 8'hEE, 0,  1'b0, 8'h42, 1'b0, 1'b1, 18};
    vecs[5]  = '{8'h13, 1'b0, 16, 1'b1, 8'hE1, 0,  1'b0, 8'hE1, 1'b1, 1'b0, 18};
    vecs[6]  = '{8'h24, 1'b0, 17, 1'b1, 8'hBB, 1,  1'b0, 8'h24, 1'b0, 1'b1, 18};
    vecs[7]  = '{8'h9A, 1'b0, 3,  1'b1, 8'h0B, 10, 1'b0, 8'h0B, 1'b1, 1'b0, 5};
    vecs[8]  = '{8'h66, 1'b0, 1,  1'b1, 8'h10, 0,  1'b0, 8'h10, 1'b1, 1'b0, 3};
    vecs[9]  = '{8'h77, 1'b0, 1,  1'b1, 8'h20, 0,  1'b0, 8'h20, 1'b1, 1'b0, 3};
    vecs[10] = '{8'h85, 1'b0, 1,  1'b1, 8'h30, 0,  1'b1, 8'h30, 1'b1, 1'b0, 3};
    vecs[11] = '{8'h86, 1'b0, 1,  1'b0, 8'h40, 0,  1'b1, 8'h86, 1'b0, 1'b0, 3};
    vecs[12] = '{8'h87, 1'b0, 2,  1'b1, 8'h50, 0,  1'b0, 8'h50, 1'b1, 1'b0, 4};

    bus.in_valid        = 1'b0;
    bus.in_symbol       = '0;
    bus.in_train        = 1'b0;
    bus.sdm_readValid   = 1'b0;
    bus.sdm_readSuccess = 1'b0;
    bus.sdm_data        = '0;
    bus.out_ready       = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rstb = 1'b1;

    for (int unsigned i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset while waiting for a response abandons the transaction.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_symbol = 8'hC7;
    bus.in_train  = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstwait_in_wait", 32'(bus.in_ready), 32'd0);
    rstb = 1'b0;
    #1;
    chk_reset_vals("rstwait");
    exp_hits = 0;
    exp_miss = 0;
    @(negedge clk);
    rstb = 1'b1;
    bus.sdm_readValid   = 1'b1;
    bus.sdm_readSuccess = 1'b1;
    bus.sdm_data        = 8'h99;
    seen = 0;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    bus.sdm_readValid = 1'b0;
    chk("rstwait_no_out_valid", seen, 32'd0);
    chk("rstwait_in_ready", 32'(bus.in_ready), 32'd1);
    chk_counts("rstwait");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
